// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and key decoder (scan code set 2).
// Receives frames on the raw PS/2 pins, tracks E0/F0 prefixes and maps the
// game/menu keys onto the shared 4-bit key codes consumed by the menu and game
// controllers.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       frame_err,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Shared key encoding
  localparam logic [3:0] key_relesed = 4'd0;
  localparam logic [3:0] key_A       = 4'd1;
  localparam logic [3:0] key_S       = 4'd2;
  localparam logic [3:0] key_W       = 4'd3;
  localparam logic [3:0] key_D       = 4'd4;
  localparam logic [3:0] key_1       = 4'd5;
  localparam logic [3:0] key_2       = 4'd6;
  localparam logic [3:0] key_3       = 4'd7;
  localparam logic [3:0] key_4       = 4'd8;
  localparam logic [3:0] key_esc     = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  // Unmapped scan codes return key_relesed, which no real key uses
  function automatic logic [3:0] map_key(input logic [7:0] code);
    case (code)
      8'h1C:   map_key = key_A;
      8'h1B:   map_key = key_S;
      8'h1D:   map_key = key_W;
      8'h23:   map_key = key_D;
      8'h16:   map_key = key_1;
      8'h1E:   map_key = key_2;
      8'h26:   map_key = key_3;
      8'h25:   map_key = key_4;
      8'h76:   map_key = key_esc;
      default: map_key = key_relesed;
    endcase
  endfunction

  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          dat_meta_q, dat_sync_q;
  logic          fall;

  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          err_q, err_d;

  logic [3:0]    key_q, key_d;
  logic          kv_q, kv_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [3:0]    mapped;

  // Two-flop synchronizers plus a delayed copy of the clock for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  // Receiver next state: bit sampling on falling edges, frame check, timeout
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;

    if (fall) begin
      tmo_d = '0;
    end else if (state_q != S_IDLE) begin
      tmo_d = tmo_q + CW'(1);
    end else begin
      tmo_d = '0;
    end

    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_sync_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = dat_sync_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_sync_q && (^{shift_q, parity_q})) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
    end
  end

  assign mapped = map_key(rx_byte_q);

  // Decoder next state: prefix tracking and make/break handling per good byte
  always_comb begin
    key_d = key_q;
    kv_d  = 1'b0;
    brk_d = brk_q;
    ext_d = ext_q;
    if (err_q) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_valid_q) begin
      if (rx_byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (rx_byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (!ext_q && mapped != key_relesed) begin
          if (brk_q) begin
            if (mapped == key_q) begin
              key_d = key_relesed;
              kv_d  = 1'b1;
            end
          end else if (mapped != key_q) begin
            key_d = mapped;
            kv_d  = 1'b1;
          end
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  // Decoder state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= key_relesed;
      kv_q  <= 1'b0;
      brk_q <= 1'b0;
      ext_q <= 1'b0;
    end else begin
      key_q <= key_d;
      kv_q  <= kv_d;
      brk_q <= brk_d;
      ext_q <= ext_d;
    end
  end

  assign key_code      = key_q;
  assign key_valid     = kv_q;
  assign frame_err     = err_q;
  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_valid_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: directed scenarios followed by random frames,
// all checked against a scan-code-level keyboard model.
module tb_ps2_key_decoder;

  localparam int unsigned TMO = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key_code;
  logic       key_valid;
  logic       frame_err;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .frame_err    (frame_err),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Pulse counters sampled away from the active edge
  int n_kv = 0, n_rxv = 0, n_err = 0, n_overlap = 0;
  always @(negedge clk) begin
    if (key_valid) n_kv++;
    if (rx_byte_valid) n_rxv++;
    if (frame_err) n_err++;
    if (key_valid && frame_err) n_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Keyboard model: held key, pending prefixes, count of expected key_valid pulses
  logic [3:0] m_key = 4'd0;
  bit         m_brk = 1'b0;
  bit         m_ext = 1'b0;
  int         m_kv  = 0;
  logic [7:0] key_tab [9] = '{8'h1C, 8'h1B, 8'h1D, 8'h23, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h76};

  function automatic logic [3:0] ref_map(input logic [7:0] b);
    for (int i = 0; i < 9; i++)
      if (key_tab[i] == b) return 4'(i + 1);
    return 4'd0;
  endfunction

  task automatic model_good(input logic [7:0] b);
    logic [3:0] k;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      k = ref_map(b);
      if (!m_ext && k != 4'd0) begin
        if (m_brk) begin
          if (k == m_key) begin m_key = 4'd0; m_kv++; end
        end else if (k != m_key) begin
          m_key = k; m_kv++;
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  int hp = 20;

  task automatic ps2_bit(input logic v);
    @(negedge clk); ps2_data = v;
    repeat (hp) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (hp) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
    int kv0, rx0, er0, mkv0, rx_at, kv_at;
    bit good;
    logic par;
    kv0 = n_kv; rx0 = n_rxv; er0 = n_err; mkv0 = m_kv;
    good = !flip_par && !bad_stop;
    par = (~^b) ^ flip_par;
    hp = $urandom_range(12, 30);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    @(negedge clk); ps2_data = !bad_stop;
    repeat (hp) @(negedge clk);
    ps2_clk = 1'b0;
    rx_at = 0; kv_at = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (rx_byte_valid && rx_at == 0) rx_at = k;
      if (key_valid && kv_at == 0) kv_at = k;
    end
    @(negedge clk); ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (hp) @(negedge clk);
    if (good) model_good(b);
    else begin m_brk = 1'b0; m_ext = 1'b0; end
    chk("rx_valid_cnt", 32'(n_rxv - rx0), 32'(good));
    chk("frame_err_cnt", 32'(n_err - er0), 32'(!good));
    if (good) begin
      chk("rx_byte", 32'(rx_byte), 32'(b));
      chk("rx_latency", 32'(rx_at), 32'd3);
    end
    chk("key_code", 32'(key_code), 32'(m_key));
    chk("key_valid_cnt", 32'(n_kv - kv0), 32'(m_kv - mkv0));
    if (m_kv != mkv0) chk("kv_latency", 32'(kv_at), 32'd4);
  endtask

  task automatic send_seq(input logic [7:0] bytes [$]);
    foreach (bytes[i]) send_frame(bytes[i], 1'b0, 1'b0);
  endtask

  int er0, rx0;
  logic [7:0] rb;

  initial begin
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_key_code", 32'(key_code), 32'd0);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_rx_byte", 32'(rx_byte), 32'd0);
    chk("rst_rx_valid", 32'(rx_byte_valid), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Press and release A
    send_seq('{8'h1C, 8'hF0, 8'h1C});
    // Typematic repeat, key change, stale break, matching break
    send_seq('{8'h1D, 8'h1D, 8'h1D, 8'h23, 8'hF0, 8'h1D, 8'hF0, 8'h23});
    // Extended make/break ignored, then esc
    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h76});
    send_seq('{8'hF0, 8'h76});
    // Bad parity, bad stop on F0 (prefix dropped), then A
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);

    // Partial frame then silence: timeout
    er0 = n_err; rx0 = n_rxv; hp = 20;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    repeat (TMO - 40) @(negedge clk);
    chk("tmo_not_early", 32'(n_err - er0), 32'd0);
    repeat (80) @(negedge clk);
    chk("tmo_err", 32'(n_err - er0), 32'd1);
    chk("tmo_no_rx", 32'(n_rxv - rx0), 32'd0);
    m_brk = 1'b0; m_ext = 1'b0;
    send_frame(8'h16, 1'b0, 1'b0);

    // Mid-frame reset while S held
    send_frame(8'h1B, 1'b0, 1'b0);
    hp = 20;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'($urandom_range(0, 1)));
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_rst_key_code", 32'(key_code), 32'd0);
    chk("mid_rst_rx_byte", 32'(rx_byte), 32'd0);
    m_key = 4'd0; m_brk = 1'b0; m_ext = 1'b0;
    repeat (3) @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h25, 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0, 1: send_frame(key_tab[$urandom_range(0, 8)], 1'b0, 1'b0);
        2: begin
          rb = ($urandom_range(0, 1) == 1) ? key_tab[$urandom_range(0, 8)] : 8'($urandom);
          send_frame(rb, 1'b0, 1'b0);
        end
        3: begin
          send_frame(8'hF0, 1'b0, 1'b0);
          send_frame(key_tab[$urandom_range(0, 8)], 1'b0, 1'b0);
        end
        4: begin
          send_frame(8'hE0, 1'b0, 1'b0);
          if ($urandom_range(0, 1) == 1) send_frame(8'hF0, 1'b0, 1'b0);
          send_frame(key_tab[$urandom_range(0, 8)], 1'b0, 1'b0);
        end
        5: send_frame(8'($urandom), 1'b1, 1'b0);
        default: send_frame(8'($urandom), 1'b0, 1'b1);
      endcase
    end

    repeat (10) @(negedge clk);
    chk("no_err_kv_overlap", 32'(n_overlap), 32'd0);
    chk("total_key_valid", 32'(n_kv), 32'(m_kv));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
